color_contour: RTL and testbench

- Sits directly downstream of the SD colour-binning loader, on the shared 640x480 xy_bin BRAM (19-bit address, 3-bit bin per pixel).
- When the top-level FSM starts it, the block scans the whole binned frame once in raster order.
- For one selected colour bin it accumulates pixel count, bounding box and coordinate sums for centroid.
- It then raises done; the top-level FSM hands the BRAM to VGA readout.
- Read-only on the BRAM: the top-level FSM drives we=0 while this block owns the address.

---
 rtl/color_contour_pkg.sv | 31 +++
 rtl/color_contour_raster_addr_gen.sv | 37 +++
 rtl/color_contour.sv | 182 ++++++++++++++++++
 tb/tb_color_contour.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/color_contour_pkg.sv
// Shared constants and types for the colour-contour scan and the raster address generator.
// Bin encodings match the values written by the SD colour-binning loader.
package color_contour_pkg;

    localparam int H_ACTIVE     = 640;
    localparam int V_ACTIVE     = 480;
    localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

    localparam int ADDR_W = 19;
    localparam int BIN_W  = 3;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;
    localparam int SUM_W  = 28;

    localparam logic [BIN_W-1:0] BIN_BLACK   = 3'd0;
    localparam logic [BIN_W-1:0] BIN_RED     = 3'd1;
    localparam logic [BIN_W-1:0] BIN_GREEN   = 3'd2;
    localparam logic [BIN_W-1:0] BIN_YELLOW  = 3'd3;
    localparam logic [BIN_W-1:0] BIN_BLUE    = 3'd4;
    localparam logic [BIN_W-1:0] BIN_MAGENTA = 3'd5;
    localparam logic [BIN_W-1:0] BIN_CYAN    = 3'd6;
    localparam logic [BIN_W-1:0] BIN_WHITE   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } cc_state_t;

endpackage

// File: rtl/color_contour_raster_addr_gen.sv
// Raster-order x/y/linear address counter; the linear address is incremented, never multiplied out.
// Shared with the VGA readout path.
module raster_addr_gen
    import color_contour_pkg::ADDR_W, color_contour_pkg::X_W, color_contour_pkg::Y_W;
#(
    parameter int H_ACTIVE = color_contour_pkg::H_ACTIVE,
    parameter int V_ACTIVE = color_contour_pkg::V_ACTIVE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              advance,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel
);

    assign last_pixel = (addr == ADDR_W'(H_ACTIVE * V_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance) begin
            addr <= addr + ADDR_W'(1);
            if (x == X_W'(H_ACTIVE - 1)) begin
                x <= '0;
                y <= y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/color_contour.sv
// Single-pass raster scan of the binned frame measuring one colour bin:
// pixel count, bounding box and coordinate sums, published together on entry to DONE.
module color_contour
    import color_contour_pkg::ADDR_W, color_contour_pkg::BIN_W, color_contour_pkg::X_W,
           color_contour_pkg::Y_W, color_contour_pkg::SUM_W, color_contour_pkg::cc_state_t,
           color_contour_pkg::IDLE, color_contour_pkg::SCAN, color_contour_pkg::DRAIN,
           color_contour_pkg::DONE;
#(
    parameter int H_ACTIVE     = color_contour_pkg::H_ACTIVE,
    parameter int V_ACTIVE     = color_contour_pkg::V_ACTIVE,
    parameter int READ_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [BIN_W-1:0]  target_bin,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [BIN_W-1:0]  bram_dout,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] pix_count,
    output logic [X_W-1:0]    min_x,
    output logic [X_W-1:0]    max_x,
    output logic [Y_W-1:0]    min_y,
    output logic [Y_W-1:0]    max_y,
    output logic [SUM_W-1:0]  sum_x,
    output logic [SUM_W-1:0]  sum_y
);

    cc_state_t         state;
    logic [BIN_W-1:0]  target;
    logic [1:0]        drain_cnt;
    logic              accept;
    logic              last_pixel;
    logic [X_W-1:0]    gen_x;
    logic [Y_W-1:0]    gen_y;

    logic              pv [READ_LATENCY];
    logic [X_W-1:0]    px [READ_LATENCY];
    logic [Y_W-1:0]    py [READ_LATENCY];

    logic              acc_found, nx_found;
    logic [ADDR_W-1:0] acc_count, nx_count;
    logic [SUM_W-1:0]  acc_sx, acc_sy, nx_sx, nx_sy;
    logic [X_W-1:0]    acc_minx, acc_maxx, nx_minx, nx_maxx;
    logic [Y_W-1:0]    acc_miny, acc_maxy, nx_miny, nx_maxy;
    logic              hit;

    assign accept = start && (state == IDLE || state == DONE);

    raster_addr_gen #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .advance    (state == SCAN && !last_pixel),
        .x          (gen_x),
        .y          (gen_y),
        .addr       (bram_addr),
        .last_pixel (last_pixel)
    );

    // Coordinates ride alongside each read so they line up with bram_dout.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pv[i] <= 1'b0;
                px[i] <= '0;
                py[i] <= '0;
            end
        end else begin
            pv[0] <= (state == SCAN);
            px[0] <= gen_x;
            py[0] <= gen_y;
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pv[i] <= pv[i-1];
                px[i] <= px[i-1];
                py[i] <= py[i-1];
            end
        end
    end

    assign hit = pv[READ_LATENCY-1] && (bram_dout == target);

    always_comb begin
        nx_found = acc_found;
        nx_count = acc_count;
        nx_sx    = acc_sx;
        nx_sy    = acc_sy;
        nx_minx  = acc_minx;
        nx_maxx  = acc_maxx;
        nx_miny  = acc_miny;
        nx_maxy  = acc_maxy;
        if (hit) begin
            nx_found = 1'b1;
            nx_count = acc_count + ADDR_W'(1);
            nx_sx    = acc_sx + SUM_W'(px[READ_LATENCY-1]);
            nx_sy    = acc_sy + SUM_W'(py[READ_LATENCY-1]);
            if (px[READ_LATENCY-1] < acc_minx) nx_minx = px[READ_LATENCY-1];
            if (px[READ_LATENCY-1] > acc_maxx) nx_maxx = px[READ_LATENCY-1];
            if (py[READ_LATENCY-1] < acc_miny) nx_miny = py[READ_LATENCY-1];
            if (py[READ_LATENCY-1] > acc_maxy) nx_maxy = py[READ_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            target    <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            pix_count <= '0;
            sum_x     <= '0;
            sum_y     <= '0;
            min_x     <= '0;
            max_x     <= '0;
            min_y     <= '0;
            max_y     <= '0;
            acc_found <= 1'b0;
            acc_count <= '0;
            acc_sx    <= '0;
            acc_sy    <= '0;
            acc_minx  <= '1;
            acc_maxx  <= '0;
            acc_miny  <= '1;
            acc_maxy  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        target    <= target_bin;
                        acc_found <= 1'b0;
                        acc_count <= '0;
                        acc_sx    <= '0;
                        acc_sy    <= '0;
                        acc_minx  <= '1;
                        acc_maxx  <= '0;
                        acc_miny  <= '1;
                        acc_maxy  <= '0;
                        done      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SCAN;
                    end
                end
                SCAN: begin
                    {acc_found, acc_count, acc_sx, acc_sy} <= {nx_found, nx_count, nx_sx, nx_sy};
                    {acc_minx, acc_maxx, acc_miny, acc_maxy} <= {nx_minx, nx_maxx, nx_miny, nx_maxy};
                    if (last_pixel) begin
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    {acc_found, acc_count, acc_sx, acc_sy} <= {nx_found, nx_count, nx_sx, nx_sy};
                    {acc_minx, acc_maxx, acc_miny, acc_maxy} <= {nx_minx, nx_maxx, nx_miny, nx_maxy};
                    drain_cnt <= drain_cnt + 2'd1;
                    // Publish from the next-state values so the final in-flight pixel is included.
                    if (drain_cnt == 2'(READ_LATENCY - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        found     <= nx_found;
                        pix_count <= nx_count;
                        sum_x     <= nx_sx;
                        sum_y     <= nx_sy;
                        min_x     <= nx_found ? nx_minx : '0;
                        max_x     <= nx_found ? nx_maxx : '0;
                        min_y     <= nx_found ? nx_miny : '0;
                        max_y     <= nx_found ? nx_maxy : '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_color_contour.sv
// Self-checking bench: three instances (READ_LATENCY 1..3) scan a reduced 64x48 frame held in a BRAM
// model; results are compared with a frame-level reference computed directly from the pixel array.
module tb_color_contour;

    localparam int TH   = 64;
    localparam int TV   = 48;
    localparam int NPIX = TH * TV;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  target_bin;

    logic [18:0] addr_w  [3];
    logic [2:0]  dout_w  [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic        found_w [3];
    logic [18:0] cnt_w   [3];
    logic [9:0]  minx_w  [3];
    logic [9:0]  maxx_w  [3];
    logic [8:0]  miny_w  [3];
    logic [8:0]  maxy_w  [3];
    logic [27:0] sx_w    [3];
    logic [27:0] sy_w    [3];

    logic [2:0]  mem [NPIX];

    int n_checks = 0;
    int n_pass   = 0;

    int e_found, e_cnt, e_minx, e_maxx, e_miny, e_maxy;
    longint e_sx, e_sy;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [2:0] dp [3];
        always @(posedge clk) begin
            dp[0] <= mem[int'(addr_w[g])];
            dp[1] <= dp[0];
            dp[2] <= dp[1];
        end
        assign dout_w[g] = dp[g];

        color_contour #(
            .H_ACTIVE     (TH),
            .V_ACTIVE     (TV),
            .READ_LATENCY (g + 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start      (start),
            .target_bin (target_bin),
            .bram_addr  (addr_w[g]),
            .bram_dout  (dout_w[g]),
            .busy       (busy_w[g]),
            .done       (done_w[g]),
            .found      (found_w[g]),
            .pix_count  (cnt_w[g]),
            .min_x      (minx_w[g]),
            .max_x      (maxx_w[g]),
            .min_y      (miny_w[g]),
            .max_y      (maxy_w[g]),
            .sum_x      (sx_w[g]),
            .sum_y      (sy_w[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model(input logic [2:0] t);
        e_found = 0; e_cnt = 0; e_sx = 0; e_sy = 0;
        e_minx = TH; e_maxx = -1; e_miny = TV; e_maxy = -1;
        for (int y = 0; y < TV; y++)
            for (int x = 0; x < TH; x++)
                if (mem[y*TH + x] == t) begin
                    e_cnt++;
                    e_sx += x;
                    e_sy += y;
                    if (x < e_minx) e_minx = x;
                    if (x > e_maxx) e_maxx = x;
                    if (y < e_miny) e_miny = y;
                    if (y > e_maxy) e_maxy = y;
                end
        e_found = (e_cnt > 0) ? 1 : 0;
        if (e_cnt == 0) begin
            e_minx = 0; e_maxx = 0; e_miny = 0; e_maxy = 0;
        end
    endtask

    task automatic run_frame(input logic [2:0] tgt, input bit mid_start);
        int lat [3];
        int cyc;
        int prev_cnt;
        prev_cnt = e_cnt;
        model(tgt);
        @(negedge clk);
        target_bin = tgt;
        start = 1'b1;
        lat = '{0, 0, 0};
        cyc = 0;
        while (cyc < NPIX + 20 && !(lat[0] != 0 && lat[1] != 0 && lat[2] != 0)) begin
            @(negedge clk);
            cyc++;
            start = mid_start && (cyc == 500);
            target_bin = 3'($urandom);
            if (cyc == 100) begin
                check("hold_count", 64'(cnt_w[1]), 64'(prev_cnt));
                check("busy_mid", 64'(busy_w[1]), 64'd1);
                check("done_mid", 64'(done_w[1]), 64'd0);
            end
            for (int g = 0; g < 3; g++)
                if (done_w[g] && lat[g] == 0) lat[g] = cyc;
        end
        for (int g = 0; g < 3; g++) begin
            check($sformatf("latency_rl%0d", g+1), 64'(lat[g]), 64'(1 + NPIX + g + 1));
            check($sformatf("busy_end_rl%0d", g+1), 64'(busy_w[g]), 64'd0);
            check($sformatf("found_rl%0d", g+1), 64'(found_w[g]), 64'(e_found));
            check($sformatf("count_rl%0d", g+1), 64'(cnt_w[g]), 64'(e_cnt));
            check($sformatf("min_x_rl%0d", g+1), 64'(minx_w[g]), 64'(e_minx));
            check($sformatf("max_x_rl%0d", g+1), 64'(maxx_w[g]), 64'(e_maxx));
            check($sformatf("min_y_rl%0d", g+1), 64'(miny_w[g]), 64'(e_miny));
            check($sformatf("max_y_rl%0d", g+1), 64'(maxy_w[g]), 64'(e_maxy));
            check($sformatf("sum_x_rl%0d", g+1), 64'(sx_w[g]), 64'(e_sx));
            check($sformatf("sum_y_rl%0d", g+1), 64'(sy_w[g]), 64'(e_sy));
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("%s_busy_rl%0d", tag, g+1), 64'(busy_w[g]), 64'd0);
            check($sformatf("%s_done_rl%0d", tag, g+1), 64'(done_w[g]), 64'd0);
            check($sformatf("%s_found_rl%0d", tag, g+1), 64'(found_w[g]), 64'd0);
            check($sformatf("%s_count_rl%0d", tag, g+1), 64'(cnt_w[g]), 64'd0);
            check($sformatf("%s_bbox_rl%0d", tag, g+1),
                  64'({minx_w[g], maxx_w[g], miny_w[g], maxy_w[g]}), 64'd0);
            check($sformatf("%s_sums_rl%0d", tag, g+1), 64'({sx_w[g], sy_w[g]}), 64'd0);
            check($sformatf("%s_addr_rl%0d", tag, g+1), 64'(addr_w[g]), 64'd0);
        end
    endtask

    task automatic fill(input int mode, input logic [2:0] v);
        for (int i = 0; i < NPIX; i++) begin
            case (mode)
                0: mem[i] = v;
                1: mem[i] = 3'($urandom_range(0, 7));
                default: mem[i] = ($urandom_range(0, 99) < 3) ? v : 3'($urandom_range(0, 7) & 3'd3);
            endcase
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        target_bin = '0;
        fill(0, 3'd0);
        e_cnt = 0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;

        run_frame(3'd5, 1'b0);

        mem[50*0 + 5*TH + 10] = 3'd5;
        run_frame(3'd5, 1'b0);

        fill(0, 3'd0);
        for (int y = 20; y <= 24; y++)
            for (int x = 10; x <= 19; x++) mem[y*TH + x] = 3'd3;
        run_frame(3'd3, 1'b0);

        fill(0, 3'd7);
        run_frame(3'd7, 1'b0);

        fill(1, 3'd0);
        for (int i = 0; i < NPIX; i++) if (mem[i] == 3'd2) mem[i] = 3'd1;
        mem[0] = 3'd2;
        mem[NPIX-1] = 3'd2;
        run_frame(3'd2, 1'b1);

        for (int k = 0; k < 2; k++) begin
            fill(2, 3'd6);
            run_frame(3'd6, 1'b0);
        end

        fill(1, 3'd0);
        @(negedge clk);
        target_bin = 3'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (998) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_reset_state("midscan_reset");
        reset = 1'b0;
        start = 1'b0;
        e_cnt = 0;
        run_frame(3'($urandom_range(0, 7)), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
